muldiv_sequencer: RTL

//   Multi-cycle controller for the RV32M extension in the execute stage. Accepts one MUL/DIV/REM
//   op from decode and runs WIDTH shift-add/shift-subtract iterations on an internal

---
 rtl/muldiv_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the execute stage.
// Shift-add multiply and restoring divide share one adder/subtractor.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   ua_q;
    logic [WIDTH-1:0]   ub_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CW-1:0]      cnt_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;

    logic               sgn_a;
    logic               sgn_b;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               res_neg;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   spec_res;

    logic               is_div;
    logic [WIDTH:0]     alu_a;
    logic [WIDTH:0]     alu_b;
    logic [WIDTH:0]     alu_sum;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   rem_d;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   result_d;

    // Operand decode at acceptance: signedness, magnitudes, special cases.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (op_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'b010:  sgn_a = 1'b1;
            default: ;
        endcase
        neg_a    = sgn_a & A_i[WIDTH-1];
        neg_b    = sgn_b & B_i[WIDTH-1];
        abs_a    = neg_a ? -A_i : A_i;
        abs_b    = neg_b ? -B_i : B_i;
        res_neg  = (op_i[2] & op_i[1]) ? neg_a : (neg_a ^ neg_b);
        div_zero = op_i[2] & (B_i == '0);
        div_ovf  = op_i[2] & ~op_i[0] & (A_i == MIN_V) & (B_i == '1);
        if (div_zero)
            spec_res = op_i[1] ? A_i : '1;
        else
            spec_res = op_i[1] ? '0 : MIN_V;
    end

    // One iteration on the shared adder: add for multiply, subtract for divide.
    always_comb begin
        is_div = op_q[2];
        if (is_div) begin
            alu_a = {rem_q, acc_q[WIDTH-1]};
            alu_b = {1'b0, ub_q};
        end else begin
            alu_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            alu_b = acc_q[0] ? {1'b0, ua_q} : '0;
        end
        alu_sum = is_div ? (alu_a - alu_b) : (alu_a + alu_b);
        if (is_div) begin
            rem_d = alu_sum[WIDTH] ? alu_a[WIDTH-1:0] : alu_sum[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~alu_sum[WIDTH]};
        end else begin
            rem_d = rem_q;
            acc_d = {alu_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up and result selection for the FIX state.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_q ? -rem_q : rem_q;
        if (op_q[2])
            result_d = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'b00)
            result_d = prod_fix[WIDTH-1:0];
        else
            result_d = prod_fix[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            ua_q     <= '0;
            ub_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        op_q    <= op_i;
                        ua_q    <= abs_a;
                        ub_q    <= abs_b;
                        neg_q   <= res_neg;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        if (div_zero || div_ovf) begin
                            result_q <= spec_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            acc_q   <= op_i[2] ? {{WIDTH{1'b0}}, abs_a}
                                               : {{WIDTH{1'b0}}, abs_b};
                            rem_q   <= '0;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIX: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
